// File: rtl/count_seq_monitor_if.sv
// count_seq_monitor_if: sample/status bundle between the counter stage and its sequence monitor.
// COUNT_MON_MATCH_EN adds match_val/match_pulse.
interface count_seq_monitor_if #(
    parameter int CNT_W  = 3,
    parameter int WRAP_W = 8,
    parameter int ERR_W  = 4
);
    logic [CNT_W-1:0]  count_in;
    logic              count_vld;
    logic              err_clr;
    logic              wrap_pulse;
    logic [WRAP_W-1:0] wrap_cnt;
    logic              seq_err;
    logic [ERR_W-1:0]  err_cnt;
    logic [1:0]        state_o;
`ifdef COUNT_MON_MATCH_EN
    logic [CNT_W-1:0]  match_val;
    logic              match_pulse;
    modport master (output count_in, count_vld, err_clr, match_val,
                    input wrap_pulse, wrap_cnt, seq_err, err_cnt, state_o, match_pulse);
    modport slave  (input count_in, count_vld, err_clr, match_val,
                    output wrap_pulse, wrap_cnt, seq_err, err_cnt, state_o, match_pulse);
`else
    modport master (output count_in, count_vld, err_clr,
                    input wrap_pulse, wrap_cnt, seq_err, err_cnt, state_o);
    modport slave  (input count_in, count_vld, err_clr,
                    output wrap_pulse, wrap_cnt, seq_err, err_cnt, state_o);
`endif
endinterface

// File: rtl/count_seq_monitor.sv
// count_seq_monitor: checks an upstream counter increments by 1 (mod 2^CNT_W), counts wraps and faults.
// Optional COUNT_MON_MATCH_EN adds a registered match_pulse on count_in==match_val.
module count_seq_monitor #(
    parameter int CNT_W  = 3,
    parameter int WRAP_W = 8,
    parameter int ERR_W  = 4
) (
    input logic clk,
    input logic rst,
    count_seq_monitor_if.slave bus
);
    typedef enum logic [1:0] {SYNC = 2'b00, TRACK = 2'b01, FAULT = 2'b10} state_t;

    state_t            state_q, state_d;
    logic [CNT_W-1:0]  prev_q, prev_d, exp_c;
    logic              wrap_pulse_q, wrap_pulse_d;
    logic [WRAP_W-1:0] wrap_cnt_q, wrap_cnt_d;
    logic              seq_err_q, seq_err_d;
    logic [ERR_W-1:0]  err_cnt_q, err_cnt_d;
    logic              hit, smp;

    assign exp_c = prev_q + CNT_W'(1);
    assign hit   = bus.count_in == exp_c;
    assign smp   = bus.count_vld && !bus.err_clr;

    always_comb begin
        state_d      = state_q;
        prev_d       = smp ? bus.count_in : prev_q;
        wrap_pulse_d = 1'b0;
        wrap_cnt_d   = wrap_cnt_q;
        seq_err_d    = seq_err_q;
        err_cnt_d    = err_cnt_q;
        case (state_q)
            SYNC:  state_d = smp ? TRACK : SYNC;
            TRACK: begin
                if (smp && hit && bus.count_in == '0) begin
                    wrap_pulse_d = 1'b1;
                    wrap_cnt_d   = &wrap_cnt_q ? wrap_cnt_q : wrap_cnt_q + WRAP_W'(1);
                end
                if (smp && !hit) begin
                    seq_err_d = 1'b1;
                    err_cnt_d = &err_cnt_q ? err_cnt_q : err_cnt_q + ERR_W'(1);
                    state_d   = FAULT;
                end
            end
            FAULT: err_cnt_d = (smp && !hit && !(&err_cnt_q)) ? err_cnt_q + ERR_W'(1) : err_cnt_q;
            default: state_d = SYNC;
        endcase
        // clear has priority over any sample in the same cycle
        if (bus.err_clr) begin
            state_d   = SYNC;
            seq_err_d = 1'b0;
        end
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_q      <= SYNC;
            prev_q       <= '0;
            wrap_pulse_q <= 1'b0;
            wrap_cnt_q   <= '0;
            seq_err_q    <= 1'b0;
            err_cnt_q    <= '0;
        end else begin
            state_q      <= state_d;
            prev_q       <= prev_d;
            wrap_pulse_q <= wrap_pulse_d;
            wrap_cnt_q   <= wrap_cnt_d;
            seq_err_q    <= seq_err_d;
            err_cnt_q    <= err_cnt_d;
        end
    end

    assign bus.wrap_pulse = wrap_pulse_q;
    assign bus.wrap_cnt   = wrap_cnt_q;
    assign bus.seq_err    = seq_err_q;
    assign bus.err_cnt    = err_cnt_q;
    assign bus.state_o    = state_q;

`ifdef COUNT_MON_MATCH_EN
    logic match_pulse_q, match_pulse_d;

    assign match_pulse_d = bus.count_vld && bus.count_in == bus.match_val;

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) match_pulse_q <= 1'b0;
        else      match_pulse_q <= match_pulse_d;
    end

    assign bus.match_pulse = match_pulse_q;
`endif
endmodule

// File: tb/tb_count_seq_monitor.sv
// tb_count_seq_monitor: directed vectors with a queue-based scoreboard for count_seq_monitor.
module tb_count_seq_monitor;
    typedef struct packed {
        logic       wp;
        logic [7:0] wc;
        logic       se;
        logic [3:0] ec;
        logic [1:0] st;
        logic       mp;
    } exp_t;

    logic clk = 1'b0;
    logic rst = 1'b0;
    int   nvec = 0;
    int   nerr = 0;
    int   mp_seen = 0;
    exp_t q[$];

    always #5 clk = ~clk;

    count_seq_monitor_if #(.CNT_W(3), .WRAP_W(8), .ERR_W(4)) bus ();
    count_seq_monitor #(.CNT_W(3), .WRAP_W(8), .ERR_W(4)) dut (.clk(clk), .rst(rst), .bus(bus.slave));

    task automatic chk(input string n, input int act, input int exp);
        nvec++;
        if (act != exp) begin
            nerr++;
            $display("FAIL %s act=%0h exp=%0h", n, act, exp);
        end
    endtask

    task automatic step(input logic v, input logic [2:0] c, input logic clr, input logic wp,
                        input logic [7:0] wc, input logic se, input logic [3:0] ec, input logic [1:0] st);
        exp_t e;
        @(negedge clk);
        bus.count_vld = v;
        bus.count_in  = c;
        bus.err_clr   = clr;
        e = '{wp: wp, wc: wc, se: se, ec: ec, st: st, mp: 1'b0};
`ifdef COUNT_MON_MATCH_EN
        e.mp = v && c == bus.match_val;
`endif
        q.push_back(e);
    endtask

    always @(posedge clk) begin
        exp_t e, a;
        #1;
        a = '{wp: bus.wrap_pulse, wc: bus.wrap_cnt, se: bus.seq_err, ec: bus.err_cnt, st: bus.state_o, mp: 1'b0};
`ifdef COUNT_MON_MATCH_EN
        a.mp = bus.match_pulse;
        if (bus.match_pulse) mp_seen++;
`endif
        if (q.size() > 0) begin
            e = q.pop_front();
            nvec++;
            if (a != e) begin
                nerr++;
                $display("FAIL vec%0d act wp=%b wc=%0d se=%b ec=%0d st=%b mp=%b exp wp=%b wc=%0d se=%b ec=%0d st=%b mp=%b",
                         nvec, a.wp, a.wc, a.se, a.ec, a.st, a.mp, e.wp, e.wc, e.se, e.ec, e.st, e.mp);
            end
        end
    end

    initial begin
        #200000;
        $display("FAIL watchdog act=timeout exp=finish");
        $fatal(1, "watchdog");
    end

    initial begin
        bus.count_vld = 1'b0;
        bus.count_in  = '0;
        bus.err_clr   = 1'b0;
`ifdef COUNT_MON_MATCH_EN
        bus.match_val = 3'd6;
`endif
        #12;
        chk("reset_out", {bus.wrap_pulse, bus.wrap_cnt, bus.seq_err, bus.err_cnt, bus.state_o}, 0);
        @(negedge clk) rst = 1'b1;
        // full count with one legal wrap
        step(1, 0, 0, 0, 0, 0, 0, 1);
        for (int i = 1; i < 8; i++) step(1, 3'(i), 0, 0, 0, 0, 0, 1);
        step(1, 0, 0, 1, 1, 0, 0, 1);
        // skip detection, then FAULT behaviour
        step(0, 0, 1, 0, 1, 0, 0, 0);
        step(1, 2, 0, 0, 1, 0, 0, 1);
        step(1, 3, 0, 0, 1, 0, 0, 1);
        step(1, 5, 0, 0, 1, 1, 1, 2);
        step(1, 6, 0, 0, 1, 1, 1, 2);
        step(1, 7, 0, 0, 1, 1, 1, 2);
        step(1, 0, 0, 0, 1, 1, 1, 2);
        step(1, 0, 0, 0, 1, 1, 2, 2);
        // clear beats a simultaneous sample
        step(1, 4, 1, 0, 1, 0, 2, 0);
        step(1, 1, 0, 0, 1, 0, 2, 1);
        step(1, 2, 0, 0, 1, 0, 2, 1);
        // gap in valid
        step(1, 3, 0, 0, 1, 0, 2, 1);
        repeat (4) step(0, 7, 0, 0, 1, 0, 2, 1);
        step(1, 4, 0, 0, 1, 0, 2, 1);
        // upstream counter reset is an error
        step(1, 0, 0, 0, 1, 1, 3, 2);
        step(0, 0, 1, 0, 1, 0, 3, 0);
        step(1, 5, 0, 0, 1, 0, 3, 1);
        step(1, 6, 0, 0, 1, 0, 3, 1);
        step(1, 7, 0, 0, 1, 0, 3, 1);
        step(1, 0, 0, 1, 2, 0, 3, 1);
        for (int p = 0; p < 3; p++) begin
            for (int i = 1; i < 8; i++) step(1, 3'(i), 0, 0, 8'(2 + p), 0, 3, 1);
            step(1, 0, 0, 1, 8'(3 + p), 0, 3, 1);
        end
        // asynchronous reset mid-cycle
        @(posedge clk);
        #2 rst = 1'b0;
        #1 chk("async_rst", {bus.wrap_pulse, bus.wrap_cnt, bus.seq_err, bus.err_cnt, bus.state_o}, 0);
        bus.count_vld = 1'b0;
        @(negedge clk) rst = 1'b1;
        // error counter saturation on a stalled value
        step(1, 0, 0, 0, 0, 0, 0, 1);
        for (int i = 0; i < 20; i++) step(1, 0, 0, 0, 0, 1, 4'(i < 14 ? i + 1 : 15), 2);
        // free-running passes
        step(0, 0, 1, 0, 0, 0, 15, 0);
        mp_seen = 0;
        for (int p = 0; p < 3; p++)
            for (int i = 0; i < 8; i++) step(1, 3'(i), 0, p > 0 && i == 0, 8'(p), 0, 15, 1);
        @(negedge clk) bus.count_vld = 1'b0;
        repeat (2) @(posedge clk);
        #2 chk("queue_drained", q.size(), 0);
`ifdef COUNT_MON_MATCH_EN
        chk("match_pulses", mp_seen, 3);
`endif
        $display("== %0d vectors applied, %0d miscompares ==", nvec, nerr);
        $finish;
    end
endmodule
